// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_pkg
//  Description : Shared types and helpers for the 4x4 keypad scanner.
//  Revision    : 1.0
// ============================================================================
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    localparam logic [3:0] COL0_DRIVE = 4'b1110;

    // Row-major legend: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_scanner_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for asynchronous inputs, resets to 1s.
//  Revision    : 1.0
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner with debounce; one pulse per press.
//  Revision    : 1.0
// ============================================================================
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 4096,
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] keypad_hori,
    output logic [3:0] keypad_vert,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_CYCLES = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

    logic [3:0]    rows;
    state_t        state_q;
    logic [1:0]    col_q;
    logic [1:0]    row_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    vert_q;
    logic [3:0]    code_q;
    logic          valid_q;
    logic          held_q;

    logic [1:0]    col_d;
    logic [3:0]    vert_d;
    logic [CW-1:0] cnt_d;
    logic [3:0]    rows_low;
    logic          one_low;
    logic [1:0]    low_idx;
    logic          row_hit;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (keypad_hori),
        .q_o   (rows)
    );

    always_comb begin
        col_d    = col_q + 2'd1;
        vert_d   = ~(4'b0001 << col_d);
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        rows_low = ~rows;
        one_low  = $onehot(rows_low);
        low_idx  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (rows_low[i]) low_idx = 2'(i);
        end
        row_hit  = ~rows[row_q];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            vert_q  <= COL0_DRIVE;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                SCAN: begin
                    if (cnt_q != SCAN_LAST) begin
                        cnt_q <= cnt_d;
                    end else begin
                        cnt_q <= '0;
                        // Multi-row hits are treated as ghosting and skipped.
                        if (one_low) begin
                            row_q   <= low_idx;
                            state_q <= DEBOUNCE;
                        end else begin
                            col_q  <= col_d;
                            vert_q <= vert_d;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (!row_hit) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        col_q   <= col_d;
                        vert_q  <= vert_d;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= HELD;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                        code_q  <= key_map(row_q, col_q);
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                HELD: begin
                    if (!row_hit) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                    end
                end
                RELEASE: begin
                    if (row_hit) begin
                        state_q <= HELD;
                    end else if (cnt_q == DEB_LAST) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        held_q  <= 1'b0;
                        col_q   <= col_d;
                        vert_q  <= vert_d;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign keypad_vert = vert_q;
    assign key_code    = code_q;
    assign key_valid   = valid_q;
    assign key_held    = held_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scanner
//  Description : Self-checking bench for keypad_scanner with a keypad model.
//  Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_keypad_scanner;

    localparam int SCAN = 4;
    localparam int DEB  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] keypad_hori;
    logic [3:0] keypad_vert;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] pressed = '0;      // bit r*4+c
    logic [3:0]  glitch_high = '0;

    int          checks = 0;
    int          failures = 0;
    int          pulses = 0;
    logic [3:0]  last_code = 4'h0;

    typedef struct {
        int         r;
        int         c;
        int         hold;
        logic [3:0] code;
    } vec_t;

    always #5 clk = ~clk;

    keypad_scanner #(.SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB)) dut (
        .clk         (clk),
        .reset       (reset),
        .keypad_hori (keypad_hori),
        .keypad_vert (keypad_vert),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_held    (key_held)
    );

    always_comb begin
        keypad_hori = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !keypad_vert[c]) keypad_hori[r] = 1'b0;
            end
            if (glitch_high[r]) keypad_hori[r] = 1'b1;
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            checks++;
            if (!$onehot(~keypad_vert)) begin
                failures++;
                $display("FAIL vert_onehot: got %b required exactly one low bit", keypad_vert);
            end
            if (key_valid) begin
                pulses++;
                last_code = key_code;
                checks++;
                if (key_held !== 1'b1) begin
                    failures++;
                    $display("FAIL held_on_pulse: got %b required 1", key_held);
                end
            end
        end
    end

    function automatic logic [3:0] ref_code(input int r, input int c);
        string s;
        byte   ch;
        s  = "123A456B789CE0FD";
        ch = s[r*4+c];
        if (ch >= "A") return 4'(ch - "A" + 10);
        return 4'(ch - "0");
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_pulse(input int start, input int budget, input string name);
        int n = 0;
        while (pulses == start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(pulses != start), 32'd1);
    endtask

    task automatic wait_held_low(input int budget, input string name);
        int n = 0;
        while (key_held && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(key_held), 32'd0);
    endtask

    task automatic wait_vert(input logic [3:0] v, input int budget, input string name);
        int n = 0;
        while (keypad_vert !== v && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(keypad_vert), 32'(v));
    endtask

    initial begin
        vec_t tbl[16];
        int   p0;

        tbl[0]  = '{0, 0, 12, 4'h1};  tbl[1]  = '{0, 1, 20, 4'h2};
        tbl[2]  = '{0, 2, 15, 4'h3};  tbl[3]  = '{0, 3, 30, 4'hA};
        tbl[4]  = '{1, 0, 10, 4'h4};  tbl[5]  = '{1, 1, 25, 4'h5};
        tbl[6]  = '{1, 2, 12, 4'h6};  tbl[7]  = '{1, 3, 18, 4'hB};
        tbl[8]  = '{2, 0, 10, 4'h7};  tbl[9]  = '{2, 1, 14, 4'h8};
        tbl[10] = '{2, 2, 22, 4'h9};  tbl[11] = '{2, 3, 11, 4'hC};
        tbl[12] = '{3, 0, 16, 4'hE};  tbl[13] = '{3, 1, 13, 4'h0};
        tbl[14] = '{3, 2, 19, 4'hF};  tbl[15] = '{3, 3, 27, 4'hD};

        cyc(3);
        reset = 1'b0;
        check("reset_code", 32'(key_code), 32'h0);
        check("reset_valid", 32'(key_valid), 32'd0);
        check("reset_held", 32'(key_held), 32'd0);

        // Idle scan: each column dwells SCAN cycles, wrapping 3 -> 0.
        for (int i = 0; i < 64; i++) begin
            check("idle_vert", 32'(keypad_vert), 32'(~(4'b0001 << ((i / SCAN) % 4)) & 4'hF));
            cyc(1);
        end
        check("idle_no_pulse", 32'(pulses), 32'd0);

        for (int i = 0; i < 16; i++) begin
            p0 = pulses;
            pressed[tbl[i].r*4 + tbl[i].c] = 1'b1;
            wait_pulse(p0, 60, "tbl_pulse");
            check("tbl_code", 32'(last_code), 32'(tbl[i].code));
            cyc(tbl[i].hold);
            check("tbl_frozen_col", 32'(keypad_vert[tbl[i].c]), 32'd0);
            pressed = '0;
            wait_held_low(40, "tbl_release");
            check("tbl_one_pulse", 32'(pulses - p0), 32'd1);
            cyc(3);
        end

        // Bounce on '9' before a clean hold.
        p0 = pulses;
        wait_vert(4'b1011, 40, "bounce_col2");
        repeat (3) begin
            pressed[10] = 1'b1; cyc(1);
            pressed[10] = 1'b0; cyc(1);
        end
        cyc(2);
        check("bounce_no_pulse", 32'(pulses), 32'(p0));
        pressed[10] = 1'b1;
        wait_pulse(p0, 60, "bounce_pulse");
        check("bounce_code", 32'(last_code), 32'h9);
        pressed = '0;
        wait_held_low(40, "bounce_release");
        check("bounce_one_pulse", 32'(pulses - p0), 32'd1);

        // Hold '5' while 'C' is pressed too: C must wait for 5's release.
        p0 = pulses;
        pressed[5] = 1'b1;
        wait_pulse(p0, 60, "lock_pulse5");
        check("lock_code5", 32'(last_code), 32'h5);
        pressed[11] = 1'b1;
        cyc(40);
        check("lock_no_c", 32'(pulses - p0), 32'd1);
        check("lock_vert", 32'(keypad_vert), 32'hD);
        check("lock_held", 32'(key_held), 32'd1);
        pressed[5] = 1'b0;
        begin
            int n = 0;
            while (keypad_vert == 4'b1101 && n < 40) begin
                cyc(1);
                n++;
            end
        end
        check("lock_resume_col2", 32'(keypad_vert), 32'hB);
        wait_pulse(p0 + 1, 60, "lock_pulse_c");
        check("lock_code_c", 32'(last_code), 32'hC);
        pressed = '0;
        wait_held_low(40, "lock_release");

        // Short high glitch while 'A' is held.
        p0 = pulses;
        pressed[3] = 1'b1;
        wait_pulse(p0, 60, "glitch_pulse");
        cyc(5);
        glitch_high[0] = 1'b1; cyc(3);
        glitch_high[0] = 1'b0; cyc(12);
        check("glitch_one_pulse", 32'(pulses - p0), 32'd1);
        check("glitch_held", 32'(key_held), 32'd1);
        pressed = '0;
        wait_held_low(40, "glitch_release");

        // Reset during debounce of '0'.
        p0 = pulses;
        pressed[13] = 1'b1;
        wait_vert(4'b1101, 40, "rst_col1");
        cyc(6);
        reset = 1'b1;
        pressed = '0;
        cyc(1);
        reset = 1'b0;
        check("rst_vert", 32'(keypad_vert), 32'hE);
        check("rst_valid", 32'(key_valid), 32'd0);
        check("rst_held", 32'(key_held), 32'd0);
        check("rst_code", 32'(key_code), 32'h0);
        cyc(40);
        check("rst_no_pulse", 32'(pulses), 32'(p0));

        // Randomized presses with bounce on both edges.
        for (int it = 0; it < 20; it++) begin
            int k;
            logic [3:0] exp;
            k   = int'($urandom_range(0, 15));
            exp = ref_code(k / 4, k % 4);
            p0  = pulses;
            cyc(int'($urandom_range(0, 7)));
            repeat ($urandom_range(0, 3)) begin
                pressed[k] = 1'b1; cyc(int'($urandom_range(1, 2)));
                pressed[k] = 1'b0; cyc(int'($urandom_range(1, 2)));
            end
            pressed[k] = 1'b1;
            wait_pulse(p0, 60, "rnd_pulse");
            check("rnd_code", 32'(last_code), 32'(exp));
            cyc(int'($urandom_range(10, 30)));
            repeat ($urandom_range(0, 2)) begin
                pressed[k] = 1'b0; cyc(int'($urandom_range(1, 2)));
                pressed[k] = 1'b1; cyc(int'($urandom_range(1, 3)));
            end
            check("rnd_held", 32'(key_held), 32'd1);
            pressed = '0;
            wait_held_low(40, "rnd_release");
            check("rnd_one_pulse", 32'(pulses - p0), 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
